// File: rtl/aq_djpeg_pkg.sv
// Shared types and helpers for the JPEG dequantisation stage.
// Define AQ_DJPEG_DQT16_EN to store 16-bit quantisation entries instead of 8-bit ones.
package aq_djpeg_pkg;

    localparam int TABLES = 4;
`ifdef AQ_DJPEG_DQT16_EN
    localparam int QW = 16;
`else
    localparam int QW = 8;
`endif

    localparam logic [2:0] COLOR_Y0 = 3'd0;
    localparam logic [2:0] COLOR_Y1 = 3'd1;
    localparam logic [2:0] COLOR_Y2 = 3'd2;
    localparam logic [2:0] COLOR_Y3 = 3'd3;
    localparam logic [2:0] COLOR_CB = 3'd4;
    localparam logic [2:0] COLOR_CR = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLOCK = 2'd1,
        S_FLUSH = 2'd2
    } stateT;

    function automatic logic [15:0] sat16(input logic signed [32:0] v);
        if (v > 33'sd32767)
            return 16'h7fff;
        else if (v < -33'sd32768)
            return 16'h8000;
        else
            return v[15:0];
    endfunction

    // Codes 6/7 are unused by the decoder and fall back to the luma table.
    function automatic logic [1:0] tableSel(input logic [5:0] compSel, input logic [2:0] color);
        case (color)
            COLOR_Y0, COLOR_Y1, COLOR_Y2, COLOR_Y3: return compSel[1:0];
            COLOR_CB: return compSel[3:2];
            COLOR_CR: return compSel[5:4];
            default:  return compSel[1:0];
        endcase
    endfunction

endpackage

// File: rtl/aq_djpeg_dqt_ram.sv
// Quantisation table store: one write port, one registered read port (read-before-write).
// Entry width follows AQ_DJPEG_DQT16_EN through the package.
module aq_djpeg_dqt_ram
    import aq_djpeg_pkg::*;
(
    input  logic          clk,
    input  logic          wrEnable,
    input  logic [7:0]    wrAddr,
    input  logic [QW-1:0] wrData,
    input  logic [7:0]    rdAddr,
    output logic [QW-1:0] rdData
);

    logic [QW-1:0] mem [TABLES*64];

    always_ff @(posedge clk) begin
        if (wrEnable)
            mem[wrAddr] <= wrData;
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/aq_djpeg_dequant.sv
// Dequantisation stage: table lookup plus saturating multiply, fixed two-cycle latency.
// AQ_DJPEG_DQT16_EN selects 16-bit table entries; otherwise DqtData[15:8] is ignored.
module aq_djpeg_dequant
    import aq_djpeg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        DataInit,
    input  logic        DqtEnable,
    input  logic [1:0]  DqtTable,
    input  logic [5:0]  DqtCount,
    input  logic [15:0] DqtData,
    input  logic [5:0]  CompTableSel,
    input  logic        HmEnable,
    input  logic [5:0]  HmAddress,
    input  logic [2:0]  HmColor,
    input  logic [15:0] HmData,
    input  logic        HmEndEnable,
    output logic        HmIdle,
    input  logic        ZzIdle,
    output logic        ZzEnable,
    output logic [5:0]  ZzAddress,
    output logic [2:0]  ZzColor,
    output logic [15:0] ZzData,
    output logic        ZzEndEnable,
    output logic        SeqError
);

    stateT state, stateNext;
    logic coefAccept, endAccept, seqErrSet;
    logic [5:0] lastAddr;
    logic s1Valid, s1End;
    logic [5:0] s1Address;
    logic [2:0] s1Color;
    logic signed [15:0] s1Data;
    logic [QW-1:0] wrData, dqtEntry;
    logic signed [32:0] coefWide, entryWide, product;

`ifdef AQ_DJPEG_DQT16_EN
    assign wrData = DqtData;
`else
    logic unused;
    assign unused = ^DqtData[15:8];
    assign wrData = DqtData[7:0];
`endif

    aq_djpeg_dqt_ram dqtRam (
        .clk      (clk),
        .wrEnable (DqtEnable),
        .wrAddr   ({DqtTable, DqtCount}),
        .wrData   (wrData),
        .rdAddr   ({tableSel(CompTableSel, HmColor), HmAddress}),
        .rdData   (dqtEntry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= stateNext;
    end

    // DataInit overrides everything; coefficients arriving while flushing are dropped.
    always_comb begin
        stateNext  = state;
        coefAccept = 1'b0;
        endAccept  = 1'b0;
        seqErrSet  = 1'b0;
        if (DataInit) begin
            stateNext = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    coefAccept = HmEnable;
                    endAccept  = HmEndEnable;
                    if (HmEndEnable)
                        stateNext = S_FLUSH;
                    else if (HmEnable)
                        stateNext = S_BLOCK;
                end
                S_BLOCK: begin
                    coefAccept = HmEnable;
                    endAccept  = HmEndEnable;
                    seqErrSet  = HmEnable && (HmAddress <= lastAddr);
                    if (HmEndEnable)
                        stateNext = S_FLUSH;
                end
                S_FLUSH: begin
                    seqErrSet = HmEnable;
                    if (ZzEndEnable)
                        stateNext = S_IDLE;
                end
                default: stateNext = S_IDLE;
            endcase
        end
    end

    assign HmIdle = ZzIdle && (state != S_FLUSH);

    assign coefWide  = 33'(s1Data);
    assign entryWide = 33'(dqtEntry);
    assign product   = coefWide * entryWide;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastAddr    <= '0;
            SeqError    <= 1'b0;
            s1Valid     <= 1'b0;
            s1End       <= 1'b0;
            s1Address   <= '0;
            s1Color     <= '0;
            s1Data      <= '0;
            ZzEnable    <= 1'b0;
            ZzEndEnable <= 1'b0;
            ZzAddress   <= '0;
            ZzColor     <= '0;
            ZzData      <= '0;
        end else begin
            if (coefAccept)
                lastAddr <= HmAddress;
            if (DataInit)
                SeqError <= 1'b0;
            else if (seqErrSet)
                SeqError <= 1'b1;
            s1Valid     <= coefAccept;
            s1End       <= endAccept;
            s1Address   <= HmAddress;
            s1Color     <= HmColor;
            s1Data      <= HmData;
            ZzEnable    <= s1Valid && !DataInit;
            ZzEndEnable <= s1End && !DataInit;
            ZzAddress   <= s1Address;
            ZzColor     <= s1Color;
            ZzData      <= sat16(product);
        end
    end

endmodule

// File: tb/tb_aq_djpeg_dequant.sv
// Self-checking bench for aq_djpeg_dequant: cycle-indexed expectation model plus literal pins.
// Builds with or without AQ_DJPEG_DQT16_EN; literal expectations follow the macro.
module tb_aq_djpeg_dequant;

    localparam int NCYC = 4096;

    logic clk, rst, DataInit, DqtEnable;
    logic [1:0] DqtTable;
    logic [5:0] DqtCount;
    logic [15:0] DqtData;
    logic [5:0] CompTableSel;
    logic HmEnable;
    logic [5:0] HmAddress;
    logic [2:0] HmColor;
    logic [15:0] HmData;
    logic HmEndEnable, HmIdle, ZzIdle, ZzEnable;
    logic [5:0] ZzAddress;
    logic [2:0] ZzColor;
    logic [15:0] ZzData;
    logic ZzEndEnable, SeqError;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit compareOn = 0;
    logic [5:0] nextSel = '0;
    logic nextZzIdle = 1'b1;

    int qt [4][64];
    bit expEn [NCYC];
    bit expEnd [NCYC];
    bit expFlush [NCYC];
    bit expSeq [NCYC];
    logic [5:0] expAddr [NCYC];
    logic [2:0] expColor [NCYC];
    logic [15:0] expData [NCYC];
    bit mInBlock = 0;
    bit mSeq = 0;
    int mLast = 0;

    aq_djpeg_dequant dut (
        .clk          (clk),
        .rst          (rst),
        .DataInit     (DataInit),
        .DqtEnable    (DqtEnable),
        .DqtTable     (DqtTable),
        .DqtCount     (DqtCount),
        .DqtData      (DqtData),
        .CompTableSel (CompTableSel),
        .HmEnable     (HmEnable),
        .HmAddress    (HmAddress),
        .HmColor      (HmColor),
        .HmData       (HmData),
        .HmEndEnable  (HmEndEnable),
        .HmIdle       (HmIdle),
        .ZzIdle       (ZzIdle),
        .ZzEnable     (ZzEnable),
        .ZzAddress    (ZzAddress),
        .ZzColor      (ZzColor),
        .ZzData       (ZzData),
        .ZzEndEnable  (ZzEndEnable),
        .SeqError     (SeqError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, actual, expected);
        end
    endtask

    // One call per clock: drive the vector, then predict what it does two cycles on.
    task automatic applyStimulus(input logic dEn, input logic [1:0] dTab, input logic [5:0] dCnt,
                                 input logic [15:0] dDat, input logic hEn, input logic [5:0] hAddr,
                                 input logic [2:0] hCol, input logic [15:0] hDat, input logic hEnd,
                                 input logic init);
        int c;
        int p;
        logic [1:0] t;
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        DqtEnable = dEn; DqtTable = dTab; DqtCount = dCnt; DqtData = dDat;
        HmEnable = hEn; HmAddress = hAddr; HmColor = hCol; HmData = hDat;
        HmEndEnable = hEnd; DataInit = init;
        CompTableSel = nextSel; ZzIdle = nextZzIdle;
        compareOn = 1;
        c = cyc;
        if (init) begin
            mSeq = 0; mInBlock = 0;
            expEn[c+1] = 0; expEnd[c+1] = 0; expFlush[c+1] = 0;
        end else if (expFlush[c]) begin
            if (hEn) mSeq = 1;
        end else begin
            if (hEn) begin
                if (mInBlock && hAddr <= mLast) mSeq = 1;
                mLast = hAddr;
                mInBlock = 1;
                case (hCol)
                    3'd4: t = nextSel[3:2];
                    3'd5: t = nextSel[5:4];
                    default: t = nextSel[1:0];
                endcase
                p = int'($signed(hDat)) * qt[t][hAddr];
                if (p > 32767) p = 32767;
                if (p < -32768) p = -32768;
                expEn[c+2] = 1; expAddr[c+2] = hAddr; expColor[c+2] = hCol; expData[c+2] = 16'(p);
            end
            if (hEnd) begin
                expEnd[c+2] = 1; expFlush[c+1] = 1; expFlush[c+2] = 1;
                mInBlock = 0;
            end
        end
        expSeq[c+1] = mSeq;
        if (dEn) begin
`ifdef AQ_DJPEG_DQT16_EN
            qt[dTab][dCnt] = int'(dDat);
`else
            qt[dTab][dCnt] = int'(dDat[7:0]);
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic dqtWrite(input logic [1:0] t, input logic [5:0] i, input logic [15:0] v);
        applyStimulus(1, t, i, v, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic coef(input logic [5:0] a, input logic [2:0] col, input logic [15:0] d, input logic e);
        applyStimulus(0, 0, 0, 0, 1, a, col, d, e, 0);
    endtask

    always @(negedge clk) begin
        if (compareOn) begin
            checkOutput("ZzEnable", ZzEnable, expEn[cyc]);
            checkOutput("ZzEndEnable", ZzEndEnable, expEnd[cyc]);
            if (expEn[cyc]) begin
                checkOutput("ZzData", ZzData, expData[cyc]);
                checkOutput("ZzAddress", ZzAddress, expAddr[cyc]);
                checkOutput("ZzColor", ZzColor, expColor[cyc]);
            end
            checkOutput("SeqError", SeqError, expSeq[cyc]);
            checkOutput("HmIdle", HmIdle, ZzIdle && !expFlush[cyc]);
        end
    end

    initial begin
        rst = 1'b1; DataInit = 0; DqtEnable = 0; DqtTable = 0; DqtCount = 0; DqtData = 0;
        CompTableSel = 0; HmEnable = 0; HmAddress = 0; HmColor = 0; HmData = 0;
        HmEndEnable = 0; ZzIdle = 0;
        #3 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstZzEnable", ZzEnable, 0);
        checkOutput("rstZzEndEnable", ZzEndEnable, 0);
        checkOutput("rstZzData", ZzData, 0);
        checkOutput("rstZzAddress", ZzAddress, 0);
        checkOutput("rstZzColor", ZzColor, 0);
        checkOutput("rstSeqError", SeqError, 0);
        checkOutput("rstHmIdle", HmIdle, 0);
        @(negedge clk);
        rst = 1'b1;

        // Table 0 all 2, then a full ascending block of coefficient 100
        for (int i = 0; i < 64; i++) dqtWrite(0, 6'(i), 16'd2);
        for (int i = 0; i < 64; i++) coef(6'(i), 0, 16'd100, i == 63);
        idle(2);
        @(negedge clk);
        checkOutput("pinFullBlockData", ZzData, 200);
        checkOutput("pinFullBlockEnd", ZzEndEnable, 1);
        checkOutput("pinFullBlockAddr", ZzAddress, 63);
        idle(1);

        // Write and read of the same entry in one cycle sees the old value
        applyStimulus(1, 0, 5, 16'd7, 1, 5, 0, 16'd100, 1, 0);
        idle(2);
        @(negedge clk);
        checkOutput("pinReadOld", ZzData, 200);
        idle(1);
        coef(5, 0, 16'd100, 1);
        idle(2);
        @(negedge clk);
        checkOutput("pinReadNew", ZzData, 700);
        idle(1);

        // Cb table select and negative saturation
        dqtWrite(1, 5, 16'h00FF);
        nextSel = 6'b010100;
        coef(5, 4, 16'hFF38, 1);
        idle(2);
        @(negedge clk);
        checkOutput("pinNegSat", ZzData, 16'h8000);
        idle(1);

        // Upper entry byte: ignored for 8-bit tables, used for 16-bit ones
        dqtWrite(2, 0, 16'h1203);
        nextSel = 6'b000010;
        coef(0, 0, 16'd10, 1);
        idle(2);
        @(negedge clk);
`ifdef AQ_DJPEG_DQT16_EN
        checkOutput("pinUpperByte", ZzData, 32767);
`else
        checkOutput("pinUpperByte", ZzData, 30);
`endif
        idle(1);

        dqtWrite(3, 0, 16'd300);
        dqtWrite(3, 1, 16'd400);
        nextSel = 6'b000011;
        coef(0, 0, 16'd100, 0);
        coef(1, 0, 16'd100, 1);
        idle(1);
        @(negedge clk);
`ifdef AQ_DJPEG_DQT16_EN
        checkOutput("pinEntry300", ZzData, 30000);
`else
        checkOutput("pinEntry300", ZzData, 4400);
`endif
        idle(1);
        @(negedge clk);
`ifdef AQ_DJPEG_DQT16_EN
        checkOutput("pinEntry400", ZzData, 32767);
`else
        checkOutput("pinEntry400", ZzData, 14400);
`endif
        idle(1);
        nextSel = 6'b000000;

        // Empty block
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        @(negedge clk);
        checkOutput("pinEmptyIdle1", HmIdle, 0);
        idle(1);
        @(negedge clk);
        checkOutput("pinEmptyEnd", ZzEndEnable, 1);
        checkOutput("pinEmptyNoCoef", ZzEnable, 0);
        checkOutput("pinEmptyIdle2", HmIdle, 0);
        idle(1);
        @(negedge clk);
        checkOutput("pinEmptyIdle3", HmIdle, 1);

        // Repeated address trips SeqError; DataInit clears it
        coef(0, 0, 16'd100, 0);
        coef(3, 0, 16'd100, 0);
        coef(3, 0, 16'd100, 0);
        @(negedge clk);
        checkOutput("pinSeqBefore", SeqError, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        checkOutput("pinSeqSet", SeqError, 1);
        idle(3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        @(negedge clk);
        checkOutput("pinSeqCleared", SeqError, 0);

        // Coefficient during flush is dropped and flagged
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        coef(0, 0, 16'd100, 0);
        idle(1);
        @(negedge clk);
        checkOutput("pinFlushSeq", SeqError, 1);
        idle(1);
        @(negedge clk);
        checkOutput("pinFlushDrop", ZzEnable, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);

        // Downstream busy forces HmIdle low
        nextZzIdle = 1'b0;
        coef(0, 1, 16'd100, 1);
        @(negedge clk);
        checkOutput("pinZzBusy", HmIdle, 0);
        idle(3);
        nextZzIdle = 1'b1;
        idle(1);

        // DataInit with two coefficients in flight
        coef(0, 0, 16'd100, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 16'd100, 0, 1);
        idle(1);
        @(negedge clk);
        checkOutput("pinInitDrop1", ZzEnable, 0);
        idle(1);
        @(negedge clk);
        checkOutput("pinInitDrop2", ZzEnable, 0);
        idle(1);

        // Asynchronous reset in the middle of a block
        coef(0, 0, 16'd100, 0);
        idle(1);
        @(posedge clk);
        #1;
        compareOn = 0;
        checkOutput("pinPreResetEn", ZzEnable, 1);
        checkOutput("pinPreResetData", ZzData, 200);
        #1 rst = 1'b0;
        #1;
        checkOutput("pinAsyncEn", ZzEnable, 0);
        checkOutput("pinAsyncData", ZzData, 0);
        checkOutput("pinAsyncIdle", HmIdle, 1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("pinAsyncNoEnd", ZzEndEnable, 0);
        checkOutput("pinAsyncNoEn", ZzEnable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
